// File: rtl/decoder24_hold.sv
// rtl/decoder24_hold.sv - 2-to-4 one-hot decoder that holds each result for HOLD_CYCLES cycles (optional accept counter: DECODER24_HOLD_COUNT_EN)
module decoder24_hold #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_in_valid,
    output logic       io_in_ready,
    input  logic [1:0] io_in_bits,
    input  logic       io_en,
    output logic [3:0] io_y,
    output logic       io_y_valid
`ifdef DECODER24_HOLD_COUNT_EN
    ,
    output logic [7:0] io_count
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] y_q, y_d;
    logic       last_cycle;
    logic       accept;

    // Ready in IDLE and in the final hold cycle so back-to-back codes need no gap.
    assign last_cycle  = (state_q == HOLD) && (cnt_q == LAST_CNT);
    assign io_in_ready = (state_q == IDLE) || last_cycle;
    assign accept      = io_in_valid && io_in_ready;
    assign io_y        = y_q;
    assign io_y_valid  = (state_q == HOLD);

    // Next-state: load a new code on accept, otherwise count through the hold window.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        if (accept) begin
            state_d = HOLD;
            cnt_d   = 8'd0;
            y_d     = io_en ? (4'b0001 << io_in_bits) : 4'b0000;
        end else if (state_q == HOLD) begin
            if (last_cycle) begin
                state_d = IDLE;
                cnt_d   = 8'd0;
                y_d     = 4'b0000;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // State, hold counter and output register; reset discards any held code.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            y_q     <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
        end
    end

`ifdef DECODER24_HOLD_COUNT_EN
    logic [7:0] count_q;

    // Accept counter, wraps naturally at 8 bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= 8'd0;
        end else if (accept) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign io_count = count_q;
`endif

endmodule

// File: tb/tb_decoder24_hold.sv
// tb/tb_decoder24_hold.sv - directed self-checking bench for decoder24_hold (HOLD_CYCLES 4 and 1)
module tb_decoder24_hold;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;

    logic       a_valid = 1'b0;
    logic [1:0] a_bits  = 2'd0;
    logic       a_en    = 1'b0;
    logic       a_ready;
    logic [3:0] a_y;
    logic       a_yv;

    logic       b_valid = 1'b0;
    logic [1:0] b_bits  = 2'd0;
    logic       b_en    = 1'b0;
    logic       b_ready;
    logic [3:0] b_y;
    logic       b_yv;

`ifdef DECODER24_HOLD_COUNT_EN
    logic [7:0] a_count;
    logic [7:0] b_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decoder24_hold #(.HOLD_CYCLES(4)) u_a (
        .clock       (clk),
        .reset       (reset),
        .io_in_valid (a_valid),
        .io_in_ready (a_ready),
        .io_in_bits  (a_bits),
        .io_en       (a_en),
        .io_y        (a_y),
        .io_y_valid  (a_yv)
`ifdef DECODER24_HOLD_COUNT_EN
        ,
        .io_count    (a_count)
`endif
    );

    decoder24_hold #(.HOLD_CYCLES(1)) u_b (
        .clock       (clk),
        .reset       (reset),
        .io_in_valid (b_valid),
        .io_in_ready (b_ready),
        .io_in_bits  (b_bits),
        .io_en       (b_en),
        .io_y        (b_y),
        .io_y_valid  (b_yv)
`ifdef DECODER24_HOLD_COUNT_EN
        ,
        .io_count    (b_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #1 reset = 1'b0;
        #2;
        check("rst_y", 32'(a_y), 32'h0);
        check("rst_yv", 32'(a_yv), 32'h0);
        check("rst_ready", 32'(a_ready), 32'h1);
        check("rst_b_ready", 32'(b_ready), 32'h1);
        tick();
        tick();
        reset = 1'b1;

        // Single accept, bits=2, en=1
        a_valid = 1'b1; a_bits = 2'd2; a_en = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("single_y", 32'(a_y), 32'h4);
            check("single_yv", 32'(a_yv), 32'h1);
            check("single_ready", 32'(a_ready), (i == 3) ? 32'h1 : 32'h0);
            tick();
        end
        check("single_end_y", 32'(a_y), 32'h0);
        check("single_end_yv", 32'(a_yv), 32'h0);
        check("single_end_ready", 32'(a_ready), 32'h1);

        // Back-to-back 0 then 3; inputs wiggled while ready is low
        a_valid = 1'b1; a_bits = 2'd0; a_en = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            a_bits = (i == 3) ? 2'd3 : 2'(i + 1);
            a_en   = (i == 3) ? 1'b1 : 1'(i & 1);
            check("b2b_first_y", 32'(a_y), 32'h1);
            check("b2b_first_yv", 32'(a_yv), 32'h1);
            tick();
        end
        a_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("b2b_second_y", 32'(a_y), 32'h8);
            check("b2b_second_yv", 32'(a_yv), 32'h1);
            tick();
        end
        check("b2b_end_y", 32'(a_y), 32'h0);
        check("b2b_end_yv", 32'(a_yv), 32'h0);

        // Accept with en=0
        a_valid = 1'b1; a_bits = 2'd1; a_en = 1'b0;
        tick();
        a_valid = 1'b0; a_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("en0_y", 32'(a_y), 32'h0);
            check("en0_yv", 32'(a_yv), 32'h1);
            tick();
        end
        check("en0_end_yv", 32'(a_yv), 32'h0);

        // Asynchronous reset in the 2nd hold cycle
        a_valid = 1'b1; a_bits = 2'd2; a_en = 1'b1;
        tick();
        a_valid = 1'b0;
        tick();
        check("pre_arst_y", 32'(a_y), 32'h4);
        #2 reset = 1'b0;
        #1;
        check("arst_y", 32'(a_y), 32'h0);
        check("arst_yv", 32'(a_yv), 32'h0);
        check("arst_ready", 32'(a_ready), 32'h1);
        #1 reset = 1'b1;

        // First edge after reset release accepts
        a_valid = 1'b1; a_bits = 2'd3; a_en = 1'b1;
        tick();
        a_valid = 1'b0;
        check("post_rst_y", 32'(a_y), 32'h8);
        check("post_rst_yv", 32'(a_yv), 32'h1);
        for (int i = 0; i < 4; i++) tick();
        check("post_rst_end_y", 32'(a_y), 32'h0);

        // HOLD_CYCLES=1: one accept per cycle
        b_valid = 1'b1; b_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_bits = 2'(i);
            check("hc1_ready", 32'(b_ready), 32'h1);
            tick();
            check("hc1_y", 32'(b_y), 32'h1 << i);
            check("hc1_yv", 32'(b_yv), 32'h1);
        end
        b_valid = 1'b0;
        tick();
        check("hc1_end_y", 32'(b_y), 32'h0);
        check("hc1_end_yv", 32'(b_yv), 32'h0);
        check("hc1_end_ready", 32'(b_ready), 32'h1);

`ifdef DECODER24_HOLD_COUNT_EN
        // Accept counter wraps after 256
        #2 reset = 1'b0;
        #1;
        check("cnt_rst", 32'(b_count), 32'h0);
        #1 reset = 1'b1;
        b_valid = 1'b1; b_bits = 2'd0;
        for (int i = 0; i < 257; i++) tick();
        b_valid = 1'b0;
        tick();
        check("cnt_wrap", 32'(b_count), 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
